// File: rtl/uart_tx_frame_pkg.sv
// Shared UART constants, frame-state encoding and baud helpers for TX and RX.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // One 8N1 frame: start, eight data bits, stop.
    localparam int unsigned UART_FRAME_SLOTS = 10;
    localparam int unsigned UART_DATA_BITS   = 8;
    // Slot index width; holds 0..9 plus the one-past-stop lookup.
    localparam int unsigned UART_SLOT_W      = 4;

    // Default baud definition shared with the receiver: base count per bit
    // plus a per-slot +1 correction that spreads the fractional part.
    localparam int unsigned                   UART_BIT_CNT  = 168;
    localparam logic [UART_FRAME_SLOTS-1:0]   UART_BIT_MASK = 10'h3df;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Total clocks in one frame for a given baud definition.
    function automatic int unsigned uart_frame_cycles(
        input int unsigned                 bit_cnt,
        input logic [UART_FRAME_SLOTS-1:0] mask
    );
        int unsigned n;
        n = bit_cnt * UART_FRAME_SLOTS;
        for (int i = 0; i < UART_FRAME_SLOTS; i++) begin
            n = n + 32'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between a producer and the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: producer holds tx_valid/tx_data until it sees tx_ready at a rising edge.
interface uart_tx_frame_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_frame_baud_table.sv
// Slot index to bit-period lookup: base count plus that slot's one-bit correction.
// Latency: combinational.
// Backpressure: none.
module uart_baud_table import uart_pkg::*; #(
    parameter int unsigned                 WIDTH      = 8,
    parameter int unsigned                 BIT_CNT    = UART_BIT_CNT,
    parameter logic [UART_FRAME_SLOTS-1:0] BIT_MASK   = UART_BIT_MASK,
    // Receiver variant: slot 0 returns half a period so sampling lands mid-bit.
    parameter bit                          HALF_START = 1'b0
) (
    input  logic [UART_SLOT_W-1:0] slot_i,
    output logic [WIDTH-1:0]       period_o
);

    localparam logic [WIDTH-1:0] BASE = WIDTH'(BIT_CNT);

    logic             corr;
    logic [WIDTH-1:0] full_period;

    // Indices past the stop slot carry no correction; callers never use them.
    always_comb begin
        corr = 1'b0;
        if (slot_i < UART_SLOT_W'(UART_FRAME_SLOTS)) begin
            corr = BIT_MASK[slot_i];
        end
        full_period = BASE + WIDTH'(corr);
        period_o    = full_period;
        if (HALF_START && (slot_i == '0)) begin
            period_o = full_period >> 1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter: one byte per handshake, registered tx line, per-slot bit periods.
// Latency: start bit appears on the edge that accepts the byte; a frame lasts the sum of ten slot periods.
// Backpressure: tx_ready is low for the whole frame; tx_valid is ignored until the line is idle again.
module uart_tx_frame import uart_pkg::*; #(
    parameter int unsigned                 WIDTH    = 8,
    parameter int unsigned                 BIT_CNT  = UART_BIT_CNT,
    parameter logic [UART_FRAME_SLOTS-1:0] BIT_MASK = UART_BIT_MASK
) (
    input  logic           CLOCK,
    input  logic           RESET_N,
    uart_tx_frame_if.slave tx_if,
    output logic           tx,
    output logic           busy
);

    // Refuse to build a counter that cannot hold the longest slot.
    if (WIDTH < 8) begin : g_chk_width
        $error("uart_tx_frame: WIDTH must be at least 8");
    end
    if (BIT_CNT < 1) begin : g_chk_min
        $error("uart_tx_frame: BIT_CNT must be at least 1");
    end
    if ((64'(BIT_CNT) + 64'd1) > ((64'd1 << WIDTH) - 64'd1)) begin : g_chk_ovf
        $error("uart_tx_frame: BIT_CNT+1 does not fit in WIDTH bits");
    end

    uart_tx_state_t              state_q, state_d;
    logic [WIDTH-1:0]            cnt_q, cnt_d;
    logic [UART_SLOT_W-1:0]      slot_q, slot_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        tx_q, tx_d;
    logic                        rdy_q, rdy_d;

    logic [UART_SLOT_W-1:0]      period_idx;
    logic [WIDTH-1:0]            period;
    logic                        cnt_zero;
    logic                        accept;
    logic                        last_data;

    assign cnt_zero  = (cnt_q == '0);
    // rdy_q mirrors state_q == IDLE, so accepting needs no path from tx_valid to tx_ready.
    assign accept    = (state_q == IDLE) && tx_if.tx_valid;
    assign last_data = (slot_q == UART_SLOT_W'(UART_DATA_BITS));

    // Period for the slot about to be entered: slot 0 from idle, otherwise the next slot.
    assign period_idx = (state_q == IDLE) ? '0 : (slot_q + UART_SLOT_W'(1));

    uart_baud_table #(
        .WIDTH      (WIDTH),
        .BIT_CNT    (BIT_CNT),
        .BIT_MASK   (BIT_MASK),
        .HALF_START (1'b0)
    ) u_baud (
        .slot_i   (period_idx),
        .period_o (period)
    );

    // FSM state register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advance one phase whenever the current slot's counter expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                 state_d = START;
            START:   if (cnt_zero)               state_d = DATA;
            DATA:    if (cnt_zero && last_data)  state_d = STOP;
            STOP:    if (cnt_zero)               state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Datapath next state: bit counter, slot index and shift register.
    always_comb begin
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = tx_if.tx_data;
                    cnt_d   = period - WIDTH'(1);
                    slot_d  = '0;
                end
            end
            START, DATA: begin
                if (cnt_zero) begin
                    cnt_d  = period - WIDTH'(1);
                    slot_d = slot_q + UART_SLOT_W'(1);
                    if (state_q == DATA) begin
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    slot_d = '0;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            default: begin
                cnt_d  = '0;
                slot_d = '0;
            end
        endcase
    end

    // Output decode from the next state so tx and tx_ready are flops that change with the state.
    always_comb begin
        tx_d  = 1'b1;
        rdy_d = 1'b0;
        case (state_d)
            IDLE:    rdy_d = 1'b1;
            START:   tx_d  = 1'b0;
            DATA:    tx_d  = shift_d[0];
            STOP:    tx_d  = 1'b1;
            default: tx_d  = 1'b1;
        endcase
    end

    // Datapath and output registers; reset drives the line high immediately.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q   <= '0;
            slot_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
        end
    end

    assign tx             = tx_q;
    assign tx_if.tx_ready = rdy_q;
    assign busy           = ~rdy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: default baud instance plus a short-period instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_frame;

    logic CLOCK = 1'b0;
    logic RESET_N;
    logic tx, busy, s_tx, s_busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] b;
    logic [9:0] frame;
    int         ta, tb2, t, n;

    uart_tx_frame_if m_if ();
    uart_tx_frame_if s_if ();

    uart_tx_frame dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .tx_if   (m_if),
        .tx      (tx),
        .busy    (busy)
    );

    uart_tx_frame #(
        .WIDTH    (8),
        .BIT_CNT  (4),
        .BIT_MASK (10'h001)
    ) dut_s (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .tx_if   (s_if),
        .tx      (s_tx),
        .busy    (s_busy)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Advance to the next sample point, 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic cur_tx(input bit sel);
        return sel ? s_tx : tx;
    endfunction

    function automatic logic cur_rdy(input bit sel);
        return sel ? s_if.tx_ready : m_if.tx_ready;
    endfunction

    // Count consecutive samples at level lvl, starting at the current sample.
    task automatic run_len(input bit sel, input logic lvl, output int len);
        len = 0;
        while ((cur_tx(sel) === lvl) && (len < 5000)) begin
            len++;
            tick();
        end
    endtask

    task automatic wait_ready(input bit sel, output int tr);
        int g;
        g = 0;
        while ((cur_rdy(sel) !== 1'b1) && (g < 5000)) begin
            tick();
            g++;
        end
        tr = (g < 5000) ? cyc : -1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Receiver model: nominal 168-clock bits, samples each bit near its middle.
    task automatic rx_decode(output logic [7:0] byte_o, output int ts);
        int g;
        g = 0;
        while ((tx !== 1'b0) && (g < 5000)) begin
            tick();
            g++;
        end
        ts = cyc;
        for (int i = 0; i < 8; i++) begin
            wait_until(ts + 168 * (i + 1) + 84);
            byte_o[i] = tx;
        end
        wait_until(ts + 168 * 9 + 84);
        chk("rx_stop_bit", tx, 1);
    endtask

    initial begin
        // Reset: line idle, ready high, not busy.
        RESET_N       = 1'b0;
        m_if.tx_valid = 1'b0;
        m_if.tx_data  = 8'h00;
        s_if.tx_valid = 1'b0;
        s_if.tx_data  = 8'h00;
        repeat (5) tick();
        chk("rst_tx", tx, 1);
        chk("rst_ready", m_if.tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_if.tx_ready, 1);
        RESET_N = 1'b1;

        // No activity without tx_valid.
        n = 0;
        repeat (2000) begin
            tick();
            if ((tx !== 1'b1) || (m_if.tx_ready !== 1'b1) || (busy !== 1'b0)) n++;
        end
        chk("idle_quiet", n, 0);

        // 0x55: alternating bits, every slot is its own run; slot 5 is one short.
        frame = {1'b1, 8'h55, 1'b0};
        m_if.tx_data  = 8'h55;
        m_if.tx_valid = 1'b1;
        tick();
        m_if.tx_valid = 1'b0;
        chk("hs_tx_low", tx, 0);
        chk("hs_ready_low", m_if.tx_ready, 0);
        chk("hs_busy", busy, 1);
        ta = cyc;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("x55_slot%0d_lvl", i), tx, frame[i]);
            run_len(1'b0, frame[i], n);
            chk($sformatf("x55_slot%0d_len", i), n, (i == 5) ? 168 : 169);
        end
        chk("x55_stop_lvl", tx, 1);
        wait_ready(1'b0, t);
        chk("x55_frame_len", t - ta, 1689);

        // Back-to-back 0x00 then 0xFF with tx_valid held.
        m_if.tx_data  = 8'h00;
        m_if.tx_valid = 1'b1;
        tick();
        m_if.tx_data  = 8'hFF;
        rx_decode(b, ta);
        chk("b2b_byte0", b, 8'h00);
        rx_decode(b, tb2);
        m_if.tx_valid = 1'b0;
        chk("b2b_byte1", b, 8'hFF);
        chk("b2b_start_gap", tb2 - ta, 1690);
        wait_ready(1'b0, t);
        chk("b2b_ready_back", t - tb2, 1689);

        // Mid-frame data change and valid pulse must not disturb or queue.
        m_if.tx_data  = 8'hC3;
        m_if.tx_valid = 1'b1;
        tick();
        m_if.tx_valid = 1'b0;
        fork
            rx_decode(b, ta);
            begin
                repeat (600) tick();
                m_if.tx_data  = 8'h00;
                m_if.tx_valid = 1'b1;
                tick();
                m_if.tx_valid = 1'b0;
            end
        join
        chk("mid_byte", b, 8'hC3);
        wait_ready(1'b0, t);
        chk("mid_frame_len", t - ta, 1689);
        n = 0;
        repeat (300) begin
            tick();
            if ((tx !== 1'b1) || (m_if.tx_ready !== 1'b1)) n++;
        end
        chk("mid_no_queue", n, 0);

        // Reset during data slot 3 of 0xA3 (data bit 2 = 0).
        m_if.tx_data  = 8'hA3;
        m_if.tx_valid = 1'b1;
        tick();
        m_if.tx_valid = 1'b0;
        ta = cyc;
        wait_until(ta + 169 * 3 + 80);
        chk("a3_slot3_lvl", tx, 0);
        RESET_N = 1'b0;
        #1;
        chk("a3_rst_tx", tx, 1);
        chk("a3_rst_ready", m_if.tx_ready, 1);
        chk("a3_rst_busy", busy, 0);
        repeat (3) tick();
        RESET_N = 1'b1;
        tick();
        chk("a3_post_ready", m_if.tx_ready, 1);
        chk("a3_post_tx", tx, 1);

        // Next byte after the aborted frame.
        m_if.tx_data  = 8'h3C;
        m_if.tx_valid = 1'b1;
        tick();
        m_if.tx_valid = 1'b0;
        rx_decode(b, ta);
        chk("x3c_byte", b, 8'h3C);
        wait_ready(1'b0, t);
        chk("x3c_frame_len", t - ta, 1689);

        // Short-period instance: start 5 clocks, other slots 4, frame 41.
        frame = {1'b1, 8'h55, 1'b0};
        s_if.tx_data  = 8'h55;
        s_if.tx_valid = 1'b1;
        tick();
        s_if.tx_valid = 1'b0;
        chk("s_hs_busy", s_busy, 1);
        ta = cyc;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("s_slot%0d_lvl", i), s_tx, frame[i]);
            run_len(1'b1, frame[i], n);
            chk($sformatf("s_slot%0d_len", i), n, (i == 0) ? 5 : 4);
        end
        wait_ready(1'b1, t);
        chk("s_frame_len", t - ta, 41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
